seq_detect_prog: RTL and testbench

Programmable serial bit-pattern detector. It is the parametrised successor to the team's fixed-pattern Moore detectors. Pattern, length and overlap mode are run-time configurable up to `MAX_LEN` bits. Input is qualified by a valid strobe, and the block keeps a saturating match counter. It sits on a serial data path after the bit-slicer and feeds status/interrupt logic through a registered, one-cycle match pulse.

---
 rtl/seq_detect_prog.sv | 108 ++++++++++
 tb/tb_seq_detect_prog.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector.
// A bit accepted on one clock edge is shifted into a history register. It is then
// compared with the stored pattern over the low `len` bits. A match produces a
// registered one-cycle pulse and increments a saturating match counter.
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0110_0111,
    parameter int                 DEF_LEN     = 7,
    parameter bit                 DEF_OVERLAP = 1'b1,
    parameter int                 CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   cfg_len_eff
);

    localparam int FILL_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] DEF_LEN_C =
        LEN_W'((DEF_LEN > MAX_LEN) ? MAX_LEN : DEF_LEN);

    // Lengths beyond the history depth fall back to the full depth.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (int'(l) > MAX_LEN) return LEN_W'(MAX_LEN);
        return l;
    endfunction

    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic [MAX_LEN-1:0] hist;
    logic [FILL_W-1:0]  fill;

    logic [MAX_LEN-1:0] hist_next;
    logic [FILL_W-1:0]  fill_inc;
    logic [MAX_LEN-1:0] mask;
    logic               hit;
    logic               accept;

    // Next history and fill values, plus the match test on the post-shift history.
    always_comb begin
        hist_next = {hist[MAX_LEN-2:0], in_bit};
        fill_inc  = (fill == FILL_W'(MAX_LEN)) ? fill : fill + FILL_W'(1);
        mask      = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (int'(len_r) > i);
        end
        hit    = (len_r != '0) &&
                 (int'(fill_inc) >= int'(len_r)) &&
                 (((hist_next ^ pattern_r) & mask) == '0);
        // A bit that arrives with a configuration write is discarded.
        accept = in_valid && !cfg_we;
    end

    // Configuration registers: defaults on reset, otherwise loaded by cfg_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_r <= DEF_PATTERN;
            len_r     <= DEF_LEN_C;
            overlap_r <= DEF_OVERLAP;
        end else if (cfg_we) begin
            pattern_r <= cfg_pattern;
            len_r     <= clamp_len(cfg_len);
            overlap_r <= cfg_overlap;
        end
    end

    // History and fill tracking. The fill restarts after a match when overlap is off.
    always_ff @(posedge clk) begin
        if (rst || cfg_we) begin
            hist <= '0;
            fill <= '0;
        end else if (in_valid) begin
            hist <= hist_next;
            fill <= (hit && !overlap_r) ? '0 : fill_inc;
        end
    end

    // Registered match pulse, one cycle after the completing bit is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            match <= 1'b0;
        end else begin
            match <= accept && hit;
        end
    end

    // Saturating match counter. A clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            match_count <= '0;
        end else if (accept && hit && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

    assign cfg_len_eff = len_r;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Testbench for seq_detect_prog.
// Two instances share all inputs: a default one and one with a 2-bit counter.
// Expected match events are queued together with their cycle and counts.
// A monitor retires the queued events as match pulses appear.
module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       cnt_clr = 1'b0;

    logic        match1, match2;
    logic [15:0] count1;
    logic [1:0]  count2;
    logic [3:0]  len_eff1, len_eff2;

    seq_detect_prog dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match1), .match_count(count1), .cfg_len_eff(len_eff1)
    );

    seq_detect_prog #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match2), .match_count(count2), .cfg_len_eff(len_eff2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int c1;
        int c2;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   c1 = 0;
    int   c2 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every observed pulse must retire one queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (match1 || match2)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_match: match1=%0b match2=%0b at cycle %0d expected none",
                         match1, match2, cyc);
            end else begin
                e = q.pop_front();
                chk("match_cycle", cyc, e.cyc);
                chk("match1", int'(match1), 1);
                chk("match2", int'(match2), 1);
                chk("count16", int'(count1), e.c1);
                chk("count2", int'(count2), e.c2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Send one bit. If hit is set, a match is expected after the accepting edge.
    task automatic send(input logic b, input bit hit, input bit clr);
        exp_t e;
        in_valid = 1'b1;
        in_bit   = b;
        cnt_clr  = clr;
        if (clr) begin
            c1 = 0;
            c2 = 0;
        end else if (hit) begin
            c1 = c1 + 1;
            c2 = (c2 < 3) ? c2 + 1 : 3;
        end
        if (hit) begin
            e.cyc = cyc + 1;
            e.c1  = c1;
            e.c2  = c2;
            q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    // Send n bits, first bit = bits[n-1]. hits[k-1] marks an expected match after bit k.
    task automatic send_bits(input logic [15:0] bits, input int n,
                             input logic [15:0] hits, input int gap);
        for (int k = 1; k <= n; k++) begin
            send(bits[n-k], hits[k-1], 1'b0);
            if (gap != 0) idle((k % 3) + gap - 1);
        end
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                       input logic with_bit, input logic b);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        in_valid    = with_bit;
        in_bit      = b;
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic settle(input string name);
        idle(3);
        chk(name, q.size(), 0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("rst_match", int'(match1), 0);
        chk("rst_count", int'(count1), 0);
        chk("rst_count2", int'(count2), 0);
        chk("rst_len_eff", int'(len_eff1), 7);

        // Default pattern 1100111, overlap: matches after bits 7 and 12
        send_bits(16'b1100111_00111, 12, 16'h0840, 0);
        settle("missed_default_ov");
        chk("count_default_ov", int'(count1), 2);
        chk("count2_default_ov", int'(count2), 2);

        // Non-overlap: only the first match
        cfg(8'b0110_0111, 4'd7, 1'b0, 1'b0, 1'b0);
        send_bits(16'b1100111_00111, 12, 16'h0040, 0);
        settle("missed_default_nov");
        chk("count_default_nov", int'(count1), 3);
        chk("count2_sat", int'(count2), 3);

        // Pattern 11: overlap gives 3 matches, non-overlap gives 2 (after bits 2 and 4)
        cfg(8'b11, 4'd2, 1'b1, 1'b0, 1'b0);
        send_bits(16'b1111, 4, 16'h000E, 0);
        settle("missed_11_ov");
        cfg(8'b11, 4'd2, 1'b0, 1'b0, 1'b0);
        send_bits(16'b1111, 4, 16'h000A, 0);
        settle("missed_11_nov");
        chk("count_after_11", int'(count1), 8);

        // in_valid gaps are transparent
        cfg(8'b0110_0111, 4'd7, 1'b1, 1'b0, 1'b0);
        send_bits(16'b1100111, 7, 16'h0040, 2);
        settle("missed_gaps");

        // cfg_we mid-pattern clears history and drops the coincident bit
        send_bits(16'b1100, 4, 16'h0000, 0);
        cfg(8'b0110_0111, 4'd7, 1'b1, 1'b1, 1'b1);
        send_bits(16'b111, 3, 16'h0000, 0);
        cfg(8'b11, 4'd2, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        cfg(8'b11, 4'd2, 1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        settle("missed_cfg_mid");
        chk("count_cfg_unaffected", int'(count1), 10);

        // Length 0 disables detection
        cfg(8'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("len_eff_zero", int'(len_eff1), 0);
        send_bits(16'b000, 3, 16'h0000, 0);

        // Length 15 clamps to 8 and detects an 8-bit pattern
        cfg(8'b1011_0011, 4'd15, 1'b1, 1'b0, 1'b0);
        chk("len_eff_clamp", int'(len_eff1), 8);
        send_bits(16'b0_1011_0011, 9, 16'h0100, 0);
        settle("missed_len8");

        // Pattern "1": back-to-back pulses; a clear coincident with a match gives 0
        cfg(8'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b1, 1'b0);
        settle("missed_clr");
        chk("count_after_clr", int'(count1), 1);
        cnt_clr = 1'b1;
        c1 = 0;
        c2 = 0;
        tick();
        cnt_clr = 1'b0;
        chk("count_clr_idle", int'(count1), 0);

        // Reset mid-stream, with the completing bit presented under reset
        cfg(8'b0110_0111, 4'd7, 1'b1, 1'b0, 1'b0);
        send_bits(16'b110011, 6, 16'h0000, 0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        c1 = 0;
        c2 = 0;
        chk("rst_mid_match", int'(match1), 0);
        chk("rst_mid_count", int'(count1), 0);
        chk("rst_mid_len_eff", int'(len_eff1), 7);
        send(1'b1, 1'b0, 1'b0);
        // Defaults restored: 1 followed by 1100111 completes the default pattern
        send_bits(16'b1100111, 7, 16'h0040, 0);
        settle("missed_after_rst");
        chk("count_after_rst", int'(count1), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
